actf_rr_scheduler: RTL and testbench

- Shares one sigmoid activation unit (sigmf followed by an enabled D flip-flop) among NREQ neuron requesters.
- Arbitrates round-robin and issues one operand per cycle into the unit, fully pipelined.
- Tracks each operand's requester tag through the unit's latency and returns the sigmoid result tagged to its owner.
- Sits between the neuron accumulators of a layer and the layer output buffer.

---
 rtl/actf_rr_scheduler_if.sv | 26 ++
 rtl/actf_rr_scheduler.sv | 65 ++++++
 tb/tb_actf_rr_scheduler.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/actf_rr_scheduler_if.sv
// actf_rr_scheduler_if: requester, activation-unit and result signals of the sigmoid scheduler.
interface actf_rr_scheduler_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int TW   = 2
);
    logic               en;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      act_in;
    logic               act_en;
    logic [DW-1:0]      act_out;
    logic               res_valid;
    logic [TW-1:0]      res_tag;
    logic [DW-1:0]      res_data;
    logic               busy;
    modport master (
        output en, req, req_data, act_out,
        input  gnt, act_in, act_en, res_valid, res_tag, res_data, busy
    );
    modport slave (
        input  en, req, req_data, act_out,
        output gnt, act_in, act_en, res_valid, res_tag, res_data, busy
    );
endinterface

// File: rtl/actf_rr_scheduler.sv
// actf_rr_scheduler: round-robin sharing of one pipelined sigmoid unit among NREQ requesters,
// with a tag pipeline that returns each result to its owner.
module actf_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int TW   = 2,
    parameter int LAT  = 1
) (
    input logic             clk,
    input logic             reset,
    actf_rr_scheduler_if.slave bus
);
    logic [TW-1:0] ptr;
    logic [TW-1:0] win;
    logic          found;
    logic [LAT:0]  vld;
    logic [TW-1:0] tag [LAT+1];

    always_comb begin : arb
        int idx;
        idx = 0;
        bus.gnt = '0;
        win = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.en && !found && bus.req[idx[TW-1:0]]) begin
                bus.gnt[idx[TW-1:0]] = 1'b1;
                win = idx[TW-1:0];
                found = 1'b1;
            end
        end
    end

    assign bus.busy = (|vld) | found;

    // Stage k of the tag pipeline lines up with the operand k cycles after issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
            vld <= '0;
            for (int k = 0; k <= LAT; k++) tag[k] <= '0;
            bus.act_in <= '0;
            bus.act_en <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_tag <= '0;
            bus.res_data <= '0;
        end else begin
            vld <= {vld[LAT-1:0], found};
            tag[0] <= win;
            for (int k = 1; k <= LAT; k++) tag[k] <= tag[k-1];
            if (found) begin
                ptr <= (win == TW'(NREQ - 1)) ? '0 : win + 1'b1;
                bus.act_in <= bus.req_data[int'(win)*DW +: DW];
            end
            bus.act_en <= found | (|vld[LAT-1:0]);
            bus.res_valid <= vld[LAT];
            if (vld[LAT]) begin
                bus.res_data <= bus.act_out;
                bus.res_tag <= tag[LAT];
            end
        end
    end
endmodule

// File: tb/tb_actf_rr_scheduler.sv
// tb_actf_rr_scheduler: directed checks of arbitration, tag return, en gating and reset.
module tb_actf_rr_scheduler;
    localparam int NREQ = 4, DW = 16, TW = 2, LAT = 1;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic force_hi = 1'b0;
    logic [DW-1:0] unit_q = '0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;

    actf_rr_scheduler_if #(.NREQ(NREQ), .DW(DW), .TW(TW)) bus();
    actf_rr_scheduler #(.NREQ(NREQ), .DW(DW), .TW(TW), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    // Hard sigmoid in Q8.8: 0.5 + x/4, clamped to [0, 1]
    function automatic logic [DW-1:0] hsig(input logic signed [DW-1:0] x);
        int v;
        v = 128 + int'(x) / 4;
        if (v < 0) v = 0;
        if (v > 256) v = 256;
        return DW'(v);
    endfunction

    always @(posedge clk) if (bus.act_en) unit_q <= hsig(bus.act_in);
    assign bus.act_out = force_hi ? 16'h7FFF : unit_q;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        bus.req = '0;
        bus.en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        bus.req = '0;
        bus.en = 1'b0;
        bus.req_data = '0;
        repeat (2) @(negedge clk);
        checks++; if (bus.act_in !== 16'h0) begin failures++; $display("FAIL reset_act_in got=%h exp=0000", bus.act_in); end
        checks++; if (bus.act_en !== 1'b0) begin failures++; $display("FAIL reset_act_en got=%b exp=0", bus.act_en); end
        checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
        checks++; if (bus.res_tag !== 2'd0) begin failures++; $display("FAIL reset_res_tag got=%0d exp=0", bus.res_tag); end
        checks++; if (bus.res_data !== 16'h0) begin failures++; $display("FAIL reset_res_data got=%h exp=0000", bus.res_data); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_single;
        do_reset();
        bus.req_data = '0;
        bus.req = 4'b0100;
        @(negedge clk);
        checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", bus.gnt); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
        tick();
        bus.req = '0;
        @(negedge clk);
        checks++; if (bus.act_en !== 1'b1 || bus.act_in !== 16'h0) begin failures++; $display("FAIL single_issue got en=%b in=%h exp en=1 in=0000", bus.act_en, bus.act_in); end
        checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL single_gnt_drop got=%b exp=0000", bus.gnt); end
        tick();
        @(negedge clk);
        checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", bus.res_valid); end
        tick();
        @(negedge clk);
        checks++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 2'd2 || bus.res_data !== 16'h0080) begin
            failures++; $display("FAIL single_result got v=%b tag=%0d data=%h exp v=1 tag=2 data=0080", bus.res_valid, bus.res_tag, bus.res_data);
        end
        tick();
        @(negedge clk);
        checks++; if (bus.res_valid !== 1'b0 || bus.res_data !== 16'h0080) begin failures++; $display("FAIL single_pulse got v=%b data=%h exp v=0 data=0080", bus.res_valid, bus.res_data); end
    endtask

    task automatic test_round_robin;
        logic [DW-1:0] exp_data [4];
        exp_data = '{16'h0080, 16'h0090, 16'h00A0, 16'h00B0};
        do_reset();
        bus.req_data = {16'h00C0, 16'h0080, 16'h0040, 16'h0000};
        for (int c = 0; c < 12; c++) begin
            bus.req = (c < 8) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            if (c < 8) begin
                checks++; if (bus.gnt !== 4'(1 << (c % 4))) begin failures++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, bus.gnt, 4'(1 << (c % 4))); end
            end
            if (c >= 3 && c <= 10) begin
                checks++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 2'((c - 3) % 4) || bus.res_data !== exp_data[(c - 3) % 4]) begin
                    failures++; $display("FAIL rr_res c=%0d got v=%b tag=%0d data=%h exp v=1 tag=%0d data=%h",
                        c, bus.res_valid, bus.res_tag, bus.res_data, (c - 3) % 4, exp_data[(c - 3) % 4]);
                end
            end
            if (c == 11) begin
                checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL rr_end got=%b exp=0", bus.res_valid); end
            end
            tick();
        end
    endtask

    task automatic test_fairness;
        logic [3:0] exp_gnt [4];
        exp_gnt = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};
        do_reset();
        bus.req = 4'b0001;
        tick();
        for (int c = 0; c < 4; c++) begin
            bus.req = 4'b1001;
            @(negedge clk);
            checks++; if (bus.gnt !== exp_gnt[c]) begin failures++; $display("FAIL fair_gnt c=%0d got=%b exp=%b", c, bus.gnt, exp_gnt[c]); end
            tick();
        end
        bus.req = '0;
        repeat (5) tick();
    endtask

    task automatic test_en_gating;
        int pulses;
        pulses = 0;
        do_reset();
        bus.req_data = {16'h00C0, 16'h0080, 16'h0040, 16'h0000};
        bus.req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            bus.en = (c < 2);
            @(negedge clk);
            if (bus.res_valid === 1'b1) pulses++;
            if (c >= 2) begin
                checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL en_gnt c=%0d got=%b exp=0000", c, bus.gnt); end
            end
            if (c == 3 || c == 4) begin
                checks++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 2'(c - 3)) begin
                    failures++; $display("FAIL en_res c=%0d got v=%b tag=%0d exp v=1 tag=%0d", c, bus.res_valid, bus.res_tag, c - 3);
                end
            end
            if (c >= 5) begin
                checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL en_busy c=%0d got=%b exp=0", c, bus.busy); end
            end
            tick();
        end
        checks++; if (pulses != 2) begin failures++; $display("FAIL en_pulses got=%0d exp=2", pulses); end
        bus.en = 1'b1;
        @(negedge clk);
        checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL en_resume got=%b exp=0100", bus.gnt); end
        tick();
        bus.req = '0;
        repeat (5) tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus.req_data = {16'h00C0, 16'h0080, 16'h0040, 16'h0000};
        bus.req = 4'b1111;
        tick();
        tick();
        reset = 1'b0;
        bus.req = '0;
        #1;
        checks++; if (bus.act_in !== 16'h0 || bus.act_en !== 1'b0) begin failures++; $display("FAIL mid_act got in=%h en=%b exp in=0000 en=0", bus.act_in, bus.act_en); end
        checks++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.gnt !== 4'b0) begin
            failures++; $display("FAIL mid_out got busy=%b v=%b gnt=%b exp 0 0 0000", bus.busy, bus.res_valid, bus.gnt);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL mid_ghost c=%0d got=%b exp=0", c, bus.res_valid); end
            tick();
        end
    endtask

    task automatic test_stale;
        bus.req_data = {16'h00C0, 16'h0080, 16'h0040, 16'h0000};
        bus.req = 4'b0010;
        tick();
        bus.req = '0;
        repeat (4) tick();
        force_hi = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (bus.res_valid !== 1'b0 || bus.res_data !== 16'h0090) begin
                failures++; $display("FAIL stale c=%0d got v=%b data=%h exp v=0 data=0090", c, bus.res_valid, bus.res_data);
            end
            tick();
        end
        force_hi = 1'b0;
    endtask

    initial begin
        bus.en = 1'b0;
        bus.req = '0;
        bus.req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_en_gating();
        test_reset_mid();
        test_stale();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
